sync_fifo_v2: RTL



---
 rtl/sync_fifo_pkg.sv | 24 ++
 rtl/sync_fifo_ram.sv | 26 ++
 rtl/sync_fifo_v2.sv | 119 +++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the sync_fifo_v2 family: width functions, parameter legality check and
// default thresholds.
package sync_fifo_pkg;

  localparam int unsigned DefaultWidth   = 16;
  localparam int unsigned DefaultDepth   = 8;
  localparam int unsigned DefaultAeLevel = 1;

  // Occupancy must represent 0..depth inclusive, hence depth + 1 codes.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit params_ok(input int unsigned width, input int unsigned depth,
                                   input int unsigned af_level, input int unsigned ae_level);
    return (width >= 1) && (depth >= 2) && (ae_level >= 1) && (ae_level < af_level) &&
           (af_level <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo_v2: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module sync_fifo_ram #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 8,
  parameter int unsigned AddrW = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with arbitrary depth, programmable almost thresholds and fill count.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise data_out is registered.
module sync_fifo_v2
  import sync_fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DefaultWidth,
  parameter int unsigned FIFO_DEPTH = DefaultDepth,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int unsigned AE_LEVEL   = DefaultAeLevel,
  localparam int unsigned CW        = cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  localparam int unsigned PW = ptr_width(FIFO_DEPTH);
  localparam logic [PW-1:0] LastPtr  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DepthCnt = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AfCnt    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AeCnt    = CW'(AE_LEVEL);

  if (!params_ok(FIFO_WIDTH, FIFO_DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
    $error("sync_fifo_v2: illegal FIFO_WIDTH/FIFO_DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic                  wr_accept, rd_accept;
  logic [FIFO_WIDTH-1:0] ram_rdata;

  assign full        = (count_q == DepthCnt);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= AfCnt);
  assign almostempty = (count_q <= AeCnt);
  assign count       = count_q;
  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  always_comb begin
    wr_accept = wr_en && !full;
    rd_accept = rd_en && !empty;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    wr_ptr_d = wr_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    rd_ptr_d = rd_ptr_q;
    if (rd_accept) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end

    count_d = count_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    dout_d = rd_accept ? ram_rdata : dout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      wr_ack_q    <= wr_accept;
      overflow_q  <= wr_en && !wr_accept;
      underflow_q <= rd_en && !rd_accept;
    end
  end

  sync_fifo_ram #(
    .Width (FIFO_WIDTH),
    .Depth (FIFO_DEPTH),
    .AddrW (PW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

`ifdef FIFO_FWFT_EN
  // Head entry shows through while occupied; when empty hold the last popped word so
  // uninitialised memory never appears on the output.
  assign data_out = empty ? dout_q : ram_rdata;
`else
  assign data_out = dout_q;
`endif

endmodule
